// File: rtl/uart_rx_64_pkg.sv
// Shared constants for the 64-bit UART link: bit timing, byte FSM encoding, word size.
package uart_rx_64_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per serial bit (integer division, 434 at 50 MHz / 115200).
    function automatic int calc_bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Cycles from the start-bit edge to its centre.
    function automatic int calc_half_cyc(input int bit_cyc);
        return bit_cyc / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte 8N1 receiver: synchronizer, falling-edge detect, baud counter and byte FSM.
module uart_rx_byte
    import uart_rx_64_pkg::*;
#(
    parameter int BIT_CYC = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_done,
    output logic       o_byte_err,
    output logic       o_idle,
    output logic       o_fall
);

    localparam int HALF_CYC = calc_half_cyc(BIT_CYC);
    localparam int CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_line;
    logic             w_fall;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_done;
    logic             r_err;

    // Two-flop synchronizer plus one delay stage for edge detection; idles high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;

    // Byte FSM: qualify start bit at its centre, sample data/stop bits mid-bit,
    // return to IDLE right after the stop sample so back-to-back frames are caught.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_line) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            // Line already back high: a glitch, not a start bit.
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_line, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (w_line) begin
                            r_done <= 1'b1;
                            r_byte <= r_shift;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_byte      = r_byte;
    assign o_byte_done = r_done;
    assign o_byte_err  = r_err;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_fall      = w_fall;

endmodule

// File: rtl/uart_rx_64.sv
// 64-bit UART receiver: assembles 8 MSB-first bytes into a word, drops partial
// words on framing errors or inter-byte timeout.
module uart_rx_64
    import uart_rx_64_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    output logic [63:0] data_64,
    output logic        data_valid,
    output logic        frame_err
);

    localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int TO_W    = $clog2(TO_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [3:0]      LAST_BYTE = 4'(BYTES_PER_WORD - 1);

    logic [7:0]      w_byte;
    logic            w_byte_done;
    logic            w_byte_err;
    logic            w_idle;
    logic            w_fall;
    logic [55:0]     r_word_sr;
    logic [3:0]      r_byte_cnt;
    logic [TO_W-1:0] r_to_cnt;

    uart_rx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_byte (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_rxd       (uart_rxd),
        .o_byte      (w_byte),
        .o_byte_done (w_byte_done),
        .o_byte_err  (w_byte_err),
        .o_idle      (w_idle),
        .o_fall      (w_fall)
    );

    // Word assembly, inter-byte timeout and output strobes. Byte events take
    // priority; the timeout only runs while a partial word sits with the FSM idle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_64    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (w_byte_done) begin
                r_word_sr <= {r_word_sr[47:0], w_byte};
                r_to_cnt  <= '0;
                if (r_byte_cnt == LAST_BYTE) begin
                    data_64    <= {r_word_sr, w_byte};
                    data_valid <= 1'b1;
                    r_byte_cnt <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end else if (w_byte_err) begin
                frame_err  <= 1'b1;
                r_byte_cnt <= '0;
                r_to_cnt   <= '0;
            end else if ((r_byte_cnt == 4'd0) || !w_idle || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TO_LAST) begin
                frame_err  <= 1'b1;
                r_byte_cnt <= '0;
                r_to_cnt   <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_64.sv
// Scoreboard bench for uart_rx_64, run at 32 clocks per bit to keep runtime short.
module tb_uart_rx_64;

    localparam int CLK_FREQ     = 3_686_400;
    localparam int BAUD         = 115200;
    localparam int TIMEOUT_BITS = 20;
    localparam int BIT          = CLK_FREQ / BAUD;   // 32

    localparam logic [63:0] W1 = 64'h2CFF_0AEF_8AE1_6865;
    localparam logic [63:0] W2 = 64'hE429_F657_A7C2_DB78;
    localparam logic [63:0] W3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W4 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W5 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] W6 = 64'h00FF_00FF_55AA_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [63:0] data_64;
    logic        data_valid;
    logic        frame_err;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   last_err_cyc = 0;
    int   t0;

    uart_rx_64 #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .data_64    (data_64),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (data_valid && frame_err) begin
            checks++;
            failures++;
            $display("FAIL both_pulses actual=valid+err required=at most one");
        end else if (data_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=valid:%0b err:%0b required=none",
                         data_valid, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                check64("pulse_kind_is_err", {63'd0, frame_err}, {63'd0, mon_e.is_err});
                if (data_valid) begin
                    last_valid_cyc = cyc;
                    if (!mon_e.is_err) check64("data_64", data_64, mon_e.data);
                end else begin
                    last_err_cyc = cyc;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        uart_rxd = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic push_word(input logic [63:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = w;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [63:0] w);
        push_word(w);
        for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8 * BIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        // Reset with idle line, then a long idle stretch must stay silent.
        rst_n    = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        check64("reset_data_64", data_64, 64'd0);
        check64("reset_data_valid", {63'd0, data_valid}, 64'd0);
        check64("reset_frame_err", {63'd0, frame_err}, 64'd0);
        repeat (CLK_FREQ / 1000) @(negedge clk);

        // Single word with latency window.
        t0 = cyc;
        send_word(W1);
        idle_bits(2);
        wait_drain("word1_drain");
        check_range("word1_latency", last_valid_cyc - t0, 79 * BIT, 80 * BIT);

        // Two words, one idle bit apart; first value held while second arrives.
        send_word(W1);
        idle_bits(1);
        push_word(W2);
        for (int i = 7; i >= 4; i--) send_byte(W2[i*8 +: 8], 1'b1);
        check64("hold_between_words", data_64, W1);
        for (int i = 3; i >= 0; i--) send_byte(W2[i*8 +: 8], 1'b1);
        idle_bits(2);
        wait_drain("word2_drain");
        check64("word2_final", data_64, W2);

        // Framing error on byte 3, then a clean word.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        push_err();
        send_byte(8'h96, 1'b0);
        idle_bits(2);
        wait_drain("framerr_drain");
        check64("framerr_data_held", data_64, W2);
        send_word(W3);
        idle_bits(2);
        wait_drain("word3_drain");

        // Timeout after 3 bytes, then a clean word.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        push_err();
        t0 = cyc;
        idle_bits(25);
        wait_drain("timeout_drain");
        check_range("timeout_time", last_err_cyc - t0, 19 * BIT, 21 * BIT);
        check64("timeout_data_held", data_64, W3);
        send_word(W4);
        idle_bits(2);
        wait_drain("word4_drain");

        // Short glitch shorter than half a bit is ignored.
        uart_rxd = 1'b0;
        repeat (BIT / 2 - 6) @(negedge clk);
        idle_bits(3);
        wait_drain("glitch_drain");

        // Reset during byte 4, then a full word.
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n    = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        check64("midframe_reset_data_64", data_64, 64'd0);
        idle_bits(2);
        send_word(W5);
        idle_bits(2);
        wait_drain("word5_drain");

        // Break: line held low gives exactly one error, then recovery.
        push_err();
        uart_rxd = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        idle_bits(2);
        wait_drain("break_drain");
        check64("break_data_held", data_64, W5);
        send_word(W6);
        idle_bits(2);
        wait_drain("word6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
